// File: rtl/eth_rx_chan_demux_if.sv
// eth_rx_chan_demux_if
// Bundles the header handshake, the inbound payload stream and the shared
// outbound payload stream (per-channel valid/ready) of eth_rx_chan_demux.
// slave  : the demux side.
// master : the surrounding logic (header/payload source and channel sinks).
interface eth_rx_chan_demux_if #(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_CHAN   = 4
);
    logic                      s_eth_hdr_valid;
    logic                      s_eth_hdr_ready;
    logic [47:0]               s_eth_dest_mac;
    logic [47:0]               s_eth_src_mac;
    logic [15:0]               s_eth_type;

    logic [DATA_WIDTH-1:0]     s_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   s_axis_tkeep;
    logic                      s_axis_tvalid;
    logic                      s_axis_tlast;
    logic                      s_axis_tuser;
    logic                      s_axis_tready;

    logic [DATA_WIDTH-1:0]     m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]   m_axis_tkeep;
    logic                      m_axis_tlast;
    logic                      m_axis_tuser;
    logic [NUM_CHAN-1:0]       m_axis_tvalid;
    logic [NUM_CHAN-1:0]       m_axis_tready;

    modport slave (
        input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        output s_eth_hdr_ready,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
        input  s_eth_hdr_ready,
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tvalid,
        output m_axis_tready
    );
endinterface

// File: rtl/eth_rx_chan_demux.sv
// eth_rx_chan_demux
// Frame-level RX demultiplexer: classifies each received header against
// NUM_CHAN (remote MAC, ethertype) entries and steers the payload to the
// lowest-numbered matching channel; unmatched frames are drained and counted.
// Optional feature macro: ETH_RX_DEMUX_STATS_EN enables the per-channel
// saturating forwarded-frame counters (otherwise chan_frame_count is 0).
module eth_rx_chan_demux #(
    parameter int DATA_WIDTH   = 512,
    parameter int NUM_CHAN     = 4,
    parameter int ACCEPT_BCAST = 1
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    eth_rx_chan_demux_if.slave       bus,
    input  logic [47:0]              local_mac,
    input  logic [48*NUM_CHAN-1:0]   chan_remote_mac,
    input  logic [16*NUM_CHAN-1:0]   chan_ethertype,
    input  logic [NUM_CHAN-1:0]      chan_enable,
    output logic [31:0]              drop_count,
    output logic [32*NUM_CHAN-1:0]   chan_frame_count
);
    localparam int SEL_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    typedef enum logic [1:0] {IDLE, MATCH, FWD, DROP} state_t;

    state_t             state, state_next;
    logic [47:0]        dest_mac, src_mac;
    logic [15:0]        eth_type;
    logic [SEL_W-1:0]   sel, hit_idx;
    logic               hit_any, dest_ok;
    logic               hdr_ready, s_ready, sel_ready;
    logic               fwd_done, drop_done;
    logic [NUM_CHAN-1:0] m_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign sel_ready = bus.m_axis_tready[sel];
    assign fwd_done  = (state == FWD)  && bus.s_axis_tvalid && sel_ready && bus.s_axis_tlast;
    assign drop_done = (state == DROP) && bus.s_axis_tvalid && bus.s_axis_tlast;

    // Entry lookup against the latched header; descending scan so the lowest index wins
    always_comb begin
        dest_ok = (dest_mac == local_mac) ||
                  ((ACCEPT_BCAST != 0) && (dest_mac == 48'hFFFF_FFFF_FFFF));
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (chan_enable[i] && dest_ok &&
                (src_mac == chan_remote_mac[48*i +: 48]) &&
                (eth_type == chan_ethertype[16*i +: 16])) begin
                hit_any = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_next;
    end

    // Next-state and handshake decode
    always_comb begin
        state_next = state;
        hdr_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = '0;
        case (state)
            IDLE: begin
                hdr_ready = 1'b1;
                if (bus.s_eth_hdr_valid) state_next = MATCH;
            end
            MATCH: begin
                state_next = hit_any ? FWD : DROP;
            end
            FWD: begin
                m_valid[sel] = bus.s_axis_tvalid;
                s_ready      = sel_ready;
                if (fwd_done) state_next = IDLE;
            end
            DROP: begin
                s_ready = 1'b1;
                if (drop_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Header fields captured on the header handshake (datapath, not reset)
    always_ff @(posedge ap_clk) begin
        if (state == IDLE && bus.s_eth_hdr_valid) begin
            dest_mac <= bus.s_eth_dest_mac;
            src_mac  <= bus.s_eth_src_mac;
            eth_type <= bus.s_eth_type;
        end
    end

    // Channel select frozen for the whole frame at the end of the lookup cycle
    always_ff @(posedge ap_clk) begin
        if (state == MATCH) sel <= hit_idx;
    end

    // Handshakes are held low while reset is asserted
    assign bus.s_eth_hdr_ready = hdr_ready & ap_rst_n;
    assign bus.s_axis_tready   = s_ready & ap_rst_n;
    assign bus.m_axis_tvalid   = ap_rst_n ? m_valid : '0;
    assign bus.m_axis_tdata    = bus.s_axis_tdata;
    assign bus.m_axis_tkeep    = bus.s_axis_tkeep;
    assign bus.m_axis_tlast    = bus.s_axis_tlast;
    assign bus.m_axis_tuser    = bus.s_axis_tuser;

    // Drained-frame counter, saturating
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)      drop_count <= '0;
        else if (drop_done) drop_count <= sat_inc(drop_count);
    end

`ifdef ETH_RX_DEMUX_STATS_EN
    // Per-channel forwarded-frame counters, saturating
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n)     chan_frame_count <= '0;
        else if (fwd_done) chan_frame_count[32*sel +: 32] <= sat_inc(chan_frame_count[32*sel +: 32]);
    end
`else
    assign chan_frame_count = '0;
`endif

endmodule

// File: tb/tb_eth_rx_chan_demux.sv
// tb_eth_rx_chan_demux
// Scoreboard bench: every forwarded beat is queued when driven and checked
// when it appears on a channel output.
module tb_eth_rx_chan_demux;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int NC = 4;
`ifdef ETH_RX_DEMUX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_00;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] MAC0  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC12 = 48'h02_00_00_00_00_02;
    localparam logic [47:0] MAC3  = 48'h02_00_00_00_00_04;

    typedef struct packed {
        logic [3:0]    chan;
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic                ap_clk;
    logic                ap_rst_n;
    logic [47:0]         local_mac;
    logic [48*NC-1:0]    chan_remote_mac;
    logic [16*NC-1:0]    chan_ethertype;
    logic [NC-1:0]       chan_enable;
    logic [31:0]         drop_count;
    logic [32*NC-1:0]    chan_frame_count;
    logic [NC-1:0]       rdy;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    exp_fc [NC];
    int    exp_drop = 0;
    beat_t exp_q[$];
    beat_t got_beat, exp_beat;

    eth_rx_chan_demux_if #(.DATA_WIDTH(DW), .NUM_CHAN(NC)) bus_if ();

    eth_rx_chan_demux #(
        .DATA_WIDTH(DW), .NUM_CHAN(NC), .ACCEPT_BCAST(1)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus(bus_if),
        .local_mac(local_mac),
        .chan_remote_mac(chan_remote_mac),
        .chan_ethertype(chan_ethertype),
        .chan_enable(chan_enable),
        .drop_count(drop_count),
        .chan_frame_count(chan_frame_count)
    );

    assign bus_if.m_axis_tready = rdy;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Output monitor: every transfer on any channel must match the queue head
    always @(negedge ap_clk) begin
        for (int c = 0; c < NC; c++) begin
            if (bus_if.m_axis_tvalid[c] && bus_if.m_axis_tready[c]) begin
                got_beat = {4'(c), bus_if.m_axis_tdata, bus_if.m_axis_tkeep,
                            bus_if.m_axis_tlast, bus_if.m_axis_tuser};
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: chan=%0d data=%h, required no beat", c, got_beat.data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (got_beat !== exp_beat) begin
                        n_fail++;
                        $display("FAIL beat: got chan=%0d data=%h keep=%h last=%b user=%b, required chan=%0d data=%h keep=%h last=%b user=%b",
                                 got_beat.chan, got_beat.data, got_beat.keep, got_beat.last, got_beat.user,
                                 exp_beat.chan, exp_beat.data, exp_beat.keep, exp_beat.last, exp_beat.user);
                    end
                end
            end
        end
    end

    function automatic logic [32*NC-1:0] fc_vec();
        logic [32*NC-1:0] v;
        v = '0;
        for (int i = 0; i < NC; i++) v[32*i +: 32] = STATS ? 32'(exp_fc[i]) : 32'd0;
        return v;
    endfunction

    task automatic set_entry(input int i, input logic [47:0] mac, input logic [15:0] typ, input bit en);
        chan_remote_mac[48*i +: 48] = mac;
        chan_ethertype[16*i +: 16]  = typ;
        chan_enable[i]              = en;
    endtask

    // Drives one frame; entered and left at a negedge. chan < 0 means the frame must be drained.
    task automatic send_frame(input logic [47:0] dest, input logic [47:0] src, input logic [15:0] typ,
                              input int nbeats, input int chan, input bit tog, input bit bad,
                              output int acc_cyc);
        int    beat, guard;
        bit    xfer, load;
        beat_t b;
        bus_if.s_eth_dest_mac  = dest;
        bus_if.s_eth_src_mac   = src;
        bus_if.s_eth_type      = typ;
        bus_if.s_eth_hdr_valid = 1'b1;
        guard = 0;
        while (bus_if.s_eth_hdr_ready !== 1'b1 && guard < 20) begin
            @(negedge ap_clk);
            guard++;
        end
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hdr_accept_timeout: hdr_ready=%b, required 1", bus_if.s_eth_hdr_ready);
        end
        acc_cyc = cyc;
        @(posedge ap_clk); #1;
        bus_if.s_eth_hdr_valid = 1'b0;
        beat = 0; guard = 0; load = 1'b1;
        while (beat < nbeats && guard < 200) begin
            if (load) begin
                b.chan = chan[3:0];
                b.data = {$urandom, $urandom};
                b.last = (beat == nbeats - 1);
                b.keep = b.last ? KW'($urandom_range(255, 1)) : '1;
                b.user = bad && b.last;
                bus_if.s_axis_tdata  = b.data;
                bus_if.s_axis_tkeep  = b.keep;
                bus_if.s_axis_tlast  = b.last;
                bus_if.s_axis_tuser  = b.user;
                bus_if.s_axis_tvalid = 1'b1;
                if (chan >= 0) exp_q.push_back(b);
                load = 1'b0;
            end
            @(negedge ap_clk);
            guard++;
            n_checks++;
            if (bus_if.s_eth_hdr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hdr_ready_midframe: got %b, required 0", bus_if.s_eth_hdr_ready);
            end
            if (chan < 0) begin
                n_checks++;
                if (bus_if.m_axis_tvalid !== '0) begin
                    n_fail++;
                    $display("FAIL drop_tvalid: got %b, required 0", bus_if.m_axis_tvalid);
                end
                if (beat > 0) begin
                    n_checks++;
                    if (bus_if.s_axis_tready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL drop_tready: got %b, required 1", bus_if.s_axis_tready);
                    end
                end
            end
            xfer = (bus_if.s_axis_tready === 1'b1);
            @(posedge ap_clk); #1;
            if (tog) rdy[3] = ~rdy[3];
            if (xfer) begin
                beat++;
                load = 1'b1;
            end
        end
        bus_if.s_axis_tvalid = 1'b0;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.s_axis_tuser  = 1'b0;
        n_checks++;
        if (beat != nbeats) begin
            n_fail++;
            $display("FAIL payload_timeout: beats accepted %0d, required %0d", beat, nbeats);
        end
        @(negedge ap_clk);
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hdr_ready_after_frame: got %b, required 1", bus_if.s_eth_hdr_ready);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL beats_outstanding: got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hdr_ready: got %b, required 0", bus_if.s_eth_hdr_ready); end
        n_checks++;
        if (bus_if.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b, required 0", bus_if.s_axis_tready); end
        n_checks++;
        if (bus_if.m_axis_tvalid !== '0) begin n_fail++; $display("FAIL rst_tvalid: got %b, required 0", bus_if.m_axis_tvalid); end
        n_checks++;
        if (drop_count !== 32'd0) begin n_fail++; $display("FAIL rst_drop_count: got %0d, required 0", drop_count); end
        n_checks++;
        if (chan_frame_count !== '0) begin n_fail++; $display("FAIL rst_chan_count: got %h, required 0", chan_frame_count); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_hdr_ready: got %b, required 1", bus_if.s_eth_hdr_ready); end
    endtask

    task automatic test_basic();
        int acc;
        set_entry(0, MAC0, 16'hFFFF, 1'b1);
        send_frame(LOCAL, MAC0, 16'hFFFF, 3, 0, 1'b0, 1'b0, acc);
        exp_fc[0]++;
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL basic_chan_count: got %h, required %h", chan_frame_count, fc_vec()); end
        n_checks++;
        if (drop_count !== 32'(exp_drop)) begin n_fail++; $display("FAIL basic_drop_count: got %0d, required %0d", drop_count, exp_drop); end
    endtask

    task automatic test_priority();
        int acc;
        set_entry(1, MAC12, 16'h88B5, 1'b1);
        set_entry(2, MAC12, 16'h88B5, 1'b1);
        send_frame(LOCAL, MAC12, 16'h88B5, 2, 1, 1'b0, 1'b0, acc);
        exp_fc[1]++;
        set_entry(1, MAC12, 16'h88B5, 1'b0);
        send_frame(LOCAL, MAC12, 16'h88B5, 2, 2, 1'b0, 1'b0, acc);
        exp_fc[2]++;
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL priority_chan_count: got %h, required %h", chan_frame_count, fc_vec()); end
    endtask

    task automatic test_drop();
        int acc;
        send_frame(LOCAL, MAC0, 16'h0800, 3, -1, 1'b0, 1'b0, acc);
        exp_drop++;
        n_checks++;
        if (drop_count !== 32'(exp_drop)) begin n_fail++; $display("FAIL drop_count: got %0d, required %0d", drop_count, exp_drop); end
        send_frame(BCAST, MAC0, 16'hFFFF, 2, 0, 1'b0, 1'b1, acc);
        exp_fc[0]++;
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL bcast_chan_count: got %h, required %h", chan_frame_count, fc_vec()); end
        n_checks++;
        if (drop_count !== 32'(exp_drop)) begin n_fail++; $display("FAIL bcast_drop_count: got %0d, required %0d", drop_count, exp_drop); end
    endtask

    task automatic test_backpressure();
        int acc;
        set_entry(3, MAC3, 16'h1234, 1'b1);
        rdy[3] = 1'b1;
        send_frame(LOCAL, MAC3, 16'h1234, 8, 3, 1'b1, 1'b0, acc);
        rdy = '1;
        exp_fc[3]++;
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL backpressure_chan_count: got %h, required %h", chan_frame_count, fc_vec()); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1;
        send_frame(LOCAL, MAC0, 16'hFFFF, 1, 0, 1'b0, 1'b0, acc0);
        send_frame(LOCAL, MAC12, 16'h88B5, 1, 2, 1'b0, 1'b0, acc1);
        exp_fc[0]++;
        exp_fc[2]++;
        n_checks++;
        if (acc1 - acc0 != 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles, required 3", acc1 - acc0); end
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL b2b_chan_count: got %h, required %h", chan_frame_count, fc_vec()); end
    endtask

    task automatic test_reset_midframe();
        int    guard, acc;
        bit    xfer;
        beat_t b;
        bus_if.s_eth_dest_mac  = LOCAL;
        bus_if.s_eth_src_mac   = MAC0;
        bus_if.s_eth_type      = 16'hFFFF;
        bus_if.s_eth_hdr_valid = 1'b1;
        @(posedge ap_clk); #1;
        bus_if.s_eth_hdr_valid = 1'b0;
        b = '{chan: 4'd0, data: {$urandom, $urandom}, keep: '1, last: 1'b0, user: 1'b0};
        bus_if.s_axis_tdata  = b.data;
        bus_if.s_axis_tkeep  = b.keep;
        bus_if.s_axis_tlast  = 1'b0;
        bus_if.s_axis_tuser  = 1'b0;
        bus_if.s_axis_tvalid = 1'b1;
        exp_q.push_back(b);
        guard = 0;
        xfer  = 1'b0;
        while (!xfer && guard < 10) begin
            @(negedge ap_clk);
            xfer = (bus_if.s_axis_tready === 1'b1);
            guard++;
            @(posedge ap_clk); #1;
        end
        n_checks++;
        if (!xfer) begin n_fail++; $display("FAIL midrst_first_beat: tready=%b, required 1", bus_if.s_axis_tready); end
        // Second beat offered while the channel stalls, then reset
        bus_if.s_axis_tdata = {$urandom, $urandom};
        rdy[0]   = 1'b0;
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        n_checks++;
        if (bus_if.m_axis_tvalid !== '0) begin n_fail++; $display("FAIL midrst_tvalid: got %b, required 0", bus_if.m_axis_tvalid); end
        n_checks++;
        if (bus_if.s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready: got %b, required 0", bus_if.s_axis_tready); end
        n_checks++;
        if (drop_count !== 32'd0) begin n_fail++; $display("FAIL midrst_drop_count: got %0d, required 0", drop_count); end
        n_checks++;
        if (chan_frame_count !== '0) begin n_fail++; $display("FAIL midrst_chan_count: got %h, required 0", chan_frame_count); end
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_hdr_ready: got %b, required 0", bus_if.s_eth_hdr_ready); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        bus_if.s_axis_tvalid = 1'b0;
        rdy = '1;
        for (int i = 0; i < NC; i++) exp_fc[i] = 0;
        exp_drop = 0;
        @(negedge ap_clk);
        n_checks++;
        if (bus_if.s_eth_hdr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_hdr_ready: got %b, required 1", bus_if.s_eth_hdr_ready); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_outstanding: got %0d, required 0", exp_q.size()); end
        // Recovery: a fresh frame goes through and is the only one counted
        send_frame(LOCAL, MAC0, 16'hFFFF, 1, 0, 1'b0, 1'b0, acc);
        exp_fc[0]++;
        n_checks++;
        if (chan_frame_count !== fc_vec()) begin n_fail++; $display("FAIL midrst_recover_count: got %h, required %h", chan_frame_count, fc_vec()); end
    endtask

    initial begin
        ap_rst_n               = 1'b0;
        local_mac              = LOCAL;
        chan_remote_mac        = '0;
        chan_ethertype         = '0;
        chan_enable            = '0;
        rdy                    = '1;
        bus_if.s_eth_hdr_valid = 1'b0;
        bus_if.s_eth_dest_mac  = '0;
        bus_if.s_eth_src_mac   = '0;
        bus_if.s_eth_type      = '0;
        bus_if.s_axis_tdata    = '0;
        bus_if.s_axis_tkeep    = '0;
        bus_if.s_axis_tvalid   = 1'b0;
        bus_if.s_axis_tlast    = 1'b0;
        bus_if.s_axis_tuser    = 1'b0;
        for (int i = 0; i < NC; i++) exp_fc[i] = 0;

        test_reset();
        test_basic();
        test_priority();
        test_drop();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();

        repeat (2) @(posedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
